// File: rtl/demux1x2_behav.sv
// 1:2 lane demultiplexer: pairs consecutive valid words onto lane 0 / lane 1,
// flushing an unpaired lane-0 word alone after MAX_GAP idle cycles.
module demux1x2_behav #(
   parameter int unsigned MAX_GAP = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] in,
   output logic [8:0] out0,
   output logic [8:0] out1,
   output logic       odd_flush,
   output logic [7:0] pair_cnt
);

   typedef enum logic {EMPTY, HOLD} state_t;

   localparam logic [7:0] GAP_LAST = 8'(MAX_GAP - 1);

   state_t     state, state_nx;
   logic [7:0] hold_reg, hold_nx;
   logic [7:0] gap_cnt, gap_nx;
   logic [7:0] cnt_nx;
   logic [8:0] out0_nx, out1_nx;
   logic       flush_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         hold_reg  <= '0;
         gap_cnt   <= '0;
         out0      <= '0;
         out1      <= '0;
         odd_flush <= 1'b0;
         pair_cnt  <= '0;
      end else begin
         state     <= state_nx;
         hold_reg  <= hold_nx;
         gap_cnt   <= gap_nx;
         out0      <= out0_nx;
         out1      <= out1_nx;
         odd_flush <= flush_nx;
         pair_cnt  <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      hold_nx  = hold_reg;
      gap_nx   = gap_cnt;
      cnt_nx   = pair_cnt;
      out0_nx  = '0;
      out1_nx  = '0;
      flush_nx = 1'b0;
      case (state)
         EMPTY: begin
            if (in[8]) begin
               hold_nx  = in[7:0];
               gap_nx   = '0;
               state_nx = HOLD;
            end
         end
         HOLD: begin
            // A valid word on the timeout edge still completes the pair.
            if (in[8]) begin
               out0_nx  = {1'b1, hold_reg};
               out1_nx  = {1'b1, in[7:0]};
               cnt_nx   = pair_cnt + 8'd1;
               state_nx = EMPTY;
            end else if (gap_cnt == GAP_LAST) begin
               out0_nx  = {1'b1, hold_reg};
               flush_nx = 1'b1;
               state_nx = EMPTY;
            end else begin
               gap_nx = gap_cnt + 8'd1;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

endmodule

// File: tb/tb_demux1x2_behav.sv
// Bench for demux1x2_behav: directed and random streams checked against a
// timestamp-based pairing model.
module tb_demux1x2_behav;

   localparam int unsigned MG = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [8:0] in = '0;
   logic [8:0] out0, out1;
   logic       odd_flush;
   logic [7:0] pair_cnt;

   int checks = 0;
   int errors = 0;

   // Model: a pending-word queue plus the edge number it arrived on.
   logic [7:0] q[$];
   int         held_edge = 0;
   int         edge_no = 0;
   logic [8:0] e0 = '0, e1 = '0;
   logic       ef = 1'b0;
   int         npairs = 0;

   demux1x2_behav #(.MAX_GAP(MG)) dut (
      .clk(clk), .reset(reset), .in(in),
      .out0(out0), .out1(out1), .odd_flush(odd_flush), .pair_cnt(pair_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_no);
      end
   endtask

   task automatic model(input logic r, input logic [8:0] w);
      e0 = '0; e1 = '0; ef = 1'b0;
      if (r) begin
         q.delete();
         npairs = 0;
      end else if (q.size() == 0) begin
         if (w[8]) begin
            q.push_back(w[7:0]);
            held_edge = edge_no;
         end
      end else if (w[8]) begin
         e0 = {1'b1, q.pop_front()};
         e1 = {1'b1, w[7:0]};
         npairs++;
      end else if (edge_no - held_edge == int'(MG)) begin
         e0 = {1'b1, q.pop_front()};
         ef = 1'b1;
      end
   endtask

   task automatic step(input logic r, input logic [8:0] w);
      @(negedge clk);
      reset = r;
      in    = w;
      @(posedge clk);
      edge_no++;
      model(r, w);
      #1;
      chk("out0", out0, e0);
      chk("out1", out1, e1);
      chk("odd_flush", {8'b0, odd_flush}, {8'b0, ef});
      chk("pair_cnt", {1'b0, pair_cnt}, {1'b0, 8'(npairs % 256)});
   endtask

   initial begin
      // Reset with all-ones input
      step(1'b1, 9'h1FF);
      step(1'b1, 9'h1FF);
      chk("rst_out0", out0, 9'h000);
      chk("rst_cnt", {1'b0, pair_cnt}, 9'h000);

      // Back-to-back stream
      step(1'b0, 9'h1A1);
      step(1'b0, 9'h1B2);
      chk("b2b_p1_out0", out0, 9'h1A1);
      chk("b2b_p1_out1", out1, 9'h1B2);
      step(1'b0, 9'h1C3);
      chk("b2b_gap_out0", out0, 9'h000);
      step(1'b0, 9'h1D4);
      chk("b2b_p2_out0", out0, 9'h1C3);
      chk("b2b_p2_out1", out1, 9'h1D4);
      chk("b2b_cnt", {1'b0, pair_cnt}, 9'd2);

      // Gap within limit
      step(1'b0, 9'h155);
      for (int i = 0; i < 3; i++) step(1'b0, 9'h0FF);
      step(1'b0, 9'h166);
      chk("gap_out0", out0, 9'h155);
      chk("gap_out1", out1, 9'h166);

      // Timeout then next pair
      step(1'b0, 9'h177);
      for (int i = 0; i < 4; i++) step(1'b0, 9'h0FF);
      chk("to_out0", out0, 9'h177);
      chk("to_flush", {8'b0, odd_flush}, 9'd1);
      chk("to_cnt", {1'b0, pair_cnt}, 9'd3);
      step(1'b0, 9'h101);
      chk("to_pulse_end", {8'b0, odd_flush}, 9'd0);
      step(1'b0, 9'h102);
      chk("to_next_out0", out0, 9'h101);

      // Reset mid-hold
      step(1'b0, 9'h1EE);
      step(1'b1, 9'h000);
      step(1'b0, 9'h111);
      chk("rmh_out0", out0, 9'h000);
      step(1'b0, 9'h122);
      chk("rmh_out0_pair", out0, 9'h111);
      chk("rmh_cnt", {1'b0, pair_cnt}, 9'd1);

      // Counter wrap: 256 back-to-back pairs
      step(1'b1, 9'h000);
      for (int i = 0; i < 512; i++) begin
         step(1'b0, {1'b1, 8'(i * 7 + 3)});
         if (i == 509) chk("wrap_255", {1'b0, pair_cnt}, 9'd255);
         if (i == 511) chk("wrap_0", {1'b0, pair_cnt}, 9'd0);
      end

      // Random traffic with idle bursts and occasional resets
      for (int i = 0; i < 1500; i++) begin
         logic r;
         logic [8:0] w;
         r = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 9) < 2)
            w = {1'b0, 8'($urandom)};
         else if ($urandom_range(0, 3) == 0)
            w = {1'b1, 8'($urandom)};
         else
            w = {($urandom_range(0, 2) == 0), 8'($urandom)};
         step(r, w);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux1x2_behav.md
# demux1x2_behav

- Splits a single 9-bit word stream (bit 8 = valid, bits 7:0 = data) into two parallel lanes.
- Consecutive valid words are paired: the first goes to lane 0 (`out0`), the second to lane 1 (`out1`).
- It is the receive-side counterpart of the 2:1 lane mux in the physical-layer datapath, so the two must round-trip.
- An unpaired word is flushed to lane 0 alone after a bounded idle gap.

## Interface

- `MAX_GAP`, 4, number of idle input cycles tolerated while holding a lane-0 word before it is flushed alone (legal range 1–255).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; dominates every other input.
- `in` input 9: bit 8 = valid, bits 7:0 = data. Bits 7:0 are don't-care when bit 8 = 0.
- `out0` output 9: lane 0 word, registered; bit 8 = valid.
- `out1` output 9: lane 1 word, registered; bit 8 = valid.
- `odd_flush` output 1: one-cycle pulse when lane 0 is emitted without a partner.
- `pair_cnt` output 8: count of complete pairs emitted, modulo 256.

## Operation

- **Internal state:**
  - `state` ∈ {EMPTY, HOLD}.
  - `hold_reg[7:0]`: the captured lane-0 byte.
  - `gap_cnt[7:0]`: idle cycles counted while in HOLD.
- **Reset** (`reset` = 1 at an edge):
  - state ← EMPTY; `hold_reg`, `gap_cnt` ← 0.
  - `out0`, `out1` ← 9'h000; `odd_flush` ← 0; `pair_cnt` ← 0.
  - A held word is discarded. `in` is ignored that cycle.
- **Default each edge:** `out0` = `out1` = 9'h000 and `odd_flush` = 0. Outputs are one-cycle pulses; invalid outputs always carry data 8'h00.
- **EMPTY:**
  - `in[8]` = 1 → `hold_reg` ← `in[7:0]`, `gap_cnt` ← 0, go to HOLD.
  - Otherwise stay in EMPTY.
- **HOLD, `in[8]` = 1** (pair complete):
  - `out0` ← {1, `hold_reg`}; `out1` ← {1, `in[7:0]`}.
  - `pair_cnt` ← `pair_cnt` + 1, wrapping 255 → 0.
  - Go to EMPTY.
- **HOLD, `in[8]` = 0, `gap_cnt` = MAX_GAP−1** (timeout):
  - `out0` ← {1, `hold_reg`}; `out1` ← 9'h000; `odd_flush` ← 1.
  - `pair_cnt` unchanged. Go to EMPTY.
- **HOLD, `in[8]` = 0, otherwise:** `gap_cnt` ← `gap_cnt` + 1, stay in HOLD.
- **Priority:** reset > valid input > timeout. A valid word arriving on the edge that would time out completes the pair; no flush.
- **Word after a flush or pair:** the state is already EMPTY, so the next valid word starts a new pair (lane 0).
- **Alignment:** lanes are never swapped. Lane 0 always carries the earlier word.

## Timing

- Word A is sampled at edge n and word B at edge n+k, with 1 ≤ k ≤ MAX_GAP.
  - `out0`/`out1` become valid after edge n+k, for exactly one cycle.
  - Latency is one cycle from the second word.
- **Back-to-back input:** valid every cycle → a pair emitted every second cycle, with outputs invalid in between. Full throughput, no stalls, no backpressure.
- **Timeout:** word A at edge n, no valid at edges n+1 … n+MAX_GAP → flush registered at edge n+MAX_GAP.
  - `out0` = {1, A} and `odd_flush` = 1 for one cycle.
  - With MAX_GAP = 1, any single idle cycle flushes.
- **Reset mid-operation:** outputs read 9'h000 in the cycle after the reset edge. The first valid word after reset deasserts is lane 0.
- **`pair_cnt`:** registered and updated on the same edge as the pair output.

## Test plan

- **Reset:** hold `reset` 2 cycles with `in` = 9'h1FF → `out0` = `out1` = 9'h000, `odd_flush` = 0, `pair_cnt` = 0.
- **Back-to-back stream:** 9'h1A1, 9'h1B2, 9'h1C3, 9'h1D4.
  - Cycle after the 2nd word: `out0` = 9'h1A1, `out1` = 9'h1B2.
  - Two cycles later: `out0` = 9'h1C3, `out1` = 9'h1D4.
  - `pair_cnt` = 2; outputs 9'h000 in the gap cycles.
- **Gap within limit** (MAX_GAP = 4): 9'h155, then 3 idle cycles (9'h0FF), then 9'h166 → single pair {9'h155, 9'h166}; `odd_flush` never asserted.
- **Timeout then next pair:** 9'h177, then 4 idle cycles.
  - Flush after the 4th idle edge: `out0` = 9'h177, `out1` = 9'h000, `odd_flush` = 1 for one cycle, `pair_cnt` unchanged.
  - Then 9'h101, 9'h102 → pair {9'h101, 9'h102}.
- **Reset mid-hold:** 9'h1EE, then `reset` for 1 cycle, then 9'h111, 9'h122 → 9'h1EE never appears; pair {9'h111, 9'h122}; `pair_cnt` = 1.
- **Counter wrap:** 256 back-to-back pairs from reset → `pair_cnt` reads 255 after pair 255 and 0 after pair 256; data on both lanes matches the input order throughout.
